// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler
// Walks the KxK kernel window for every output pixel of one convolution
// layer pass. For each pixel it clears the MAC accumulator, steps the taps,
// waits one flush cycle for the MAC pipeline, then offers the partial sum to
// the downstream consumer with a valid/ready handshake.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cfg_load                   capture kernel/width/height (only while idle)
//   cfg_kernel/width/height    layer geometry K, W, H
//   start, abort               begin a pass / abandon the current pass
//   busy, done, cfg_err        status: working, end-of-pass pulse, refused start
//   mac_clr, mac_en            accumulator clear / accumulate strobes
//   kr, kc                     current kernel tap
//   in_row, in_col             input-map coordinate (out + tap)
//   out_row, out_col           current output pixel
//   psum_valid, psum_ready     partial-sum handshake to the consumer
module conv_window_scheduler #(
   parameter int DIM_W = 6,
   parameter int K_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_load,
   input  logic [K_W-1:0]   cfg_kernel,
   input  logic [DIM_W-1:0] cfg_width,
   input  logic [DIM_W-1:0] cfg_height,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [K_W-1:0]   kr,
   output logic [K_W-1:0]   kc,
   output logic [DIM_W-1:0] in_row,
   output logic [DIM_W-1:0] in_col,
   output logic [DIM_W-1:0] out_row,
   output logic [DIM_W-1:0] out_col,
   output logic             psum_valid,
   input  logic             psum_ready
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ACCUM = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       state, nxt_state;
   logic [K_W-1:0]   cfg_k;
   logic [DIM_W-1:0] cfg_w, cfg_h;

   logic [K_W-1:0]   nxt_kr, nxt_kc;
   logic [DIM_W-1:0] nxt_out_row, nxt_out_col;
   logic             nxt_mac_clr, nxt_mac_en, nxt_psum_valid, nxt_done, nxt_cfg_err;
   logic             nxt_busy;

   logic [K_W-1:0]   k_m1;
   logic [DIM_W-1:0] ow_m1, oh_m1;
   logic             cfg_bad, last_tap;

   // Derived geometry. ow_m1/oh_m1 are the last valid output column/row;
   // they are only meaningful once the stored config has passed cfg_bad.
   assign k_m1     = cfg_k - K_W'(1);
   assign ow_m1    = cfg_w - DIM_W'(cfg_k);
   assign oh_m1    = cfg_h - DIM_W'(cfg_k);
   assign cfg_bad  = (cfg_k == '0) || (DIM_W'(cfg_k) > cfg_w) || (DIM_W'(cfg_k) > cfg_h);
   assign last_tap = (kr == k_m1) && (kc == k_m1);

   // Next-state and next-output logic. Every output is registered, so this
   // block computes what each output must show in the cycle after the edge.
   // Abort outranks everything but reset and zeroes the whole pass.
   always_comb begin
      nxt_state      = state;
      nxt_kr         = kr;
      nxt_kc         = kc;
      nxt_out_row    = out_row;
      nxt_out_col    = out_col;
      nxt_mac_clr    = 1'b0;
      nxt_mac_en     = 1'b0;
      nxt_psum_valid = 1'b0;
      nxt_done       = 1'b0;
      nxt_cfg_err    = 1'b0;
      if (abort && (state != S_IDLE)) begin
         nxt_state   = S_IDLE;
         nxt_kr      = '0;
         nxt_kc      = '0;
         nxt_out_row = '0;
         nxt_out_col = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_bad) begin
                     nxt_cfg_err = 1'b1;
                  end else begin
                     nxt_state   = S_CLEAR;
                     nxt_mac_clr = 1'b1;
                     nxt_kr      = '0;
                     nxt_kc      = '0;
                     nxt_out_row = '0;
                     nxt_out_col = '0;
                  end
               end
            end
            S_CLEAR: begin
               nxt_state  = S_ACCUM;
               nxt_mac_en = 1'b1;
               nxt_kr     = '0;
               nxt_kc     = '0;
            end
            S_ACCUM: begin
               // The last tap holds kr/kc at K-1 through flush and wait.
               if (last_tap) begin
                  nxt_state = S_FLUSH;
               end else begin
                  nxt_mac_en = 1'b1;
                  if (kc == k_m1) begin
                     nxt_kc = '0;
                     nxt_kr = kr + K_W'(1);
                  end else begin
                     nxt_kc = kc + K_W'(1);
                  end
               end
            end
            S_FLUSH: begin
               nxt_state      = S_WAIT;
               nxt_psum_valid = 1'b1;
            end
            S_WAIT: begin
               if (psum_ready) begin
                  if (out_col < ow_m1) begin
                     nxt_out_col = out_col + DIM_W'(1);
                     nxt_state   = S_CLEAR;
                  end else begin
                     nxt_out_col = '0;
                     if (out_row < oh_m1) begin
                        nxt_out_row = out_row + DIM_W'(1);
                        nxt_state   = S_CLEAR;
                     end else begin
                        nxt_state = S_DONE;
                        nxt_done  = 1'b1;
                     end
                  end
                  if (nxt_state == S_CLEAR) begin
                     nxt_mac_clr = 1'b1;
                     nxt_kr      = '0;
                     nxt_kc      = '0;
                  end
               end else begin
                  nxt_psum_valid = 1'b1;
               end
            end
            S_DONE: begin
               nxt_state   = S_IDLE;
               nxt_kr      = '0;
               nxt_kc      = '0;
               nxt_out_row = '0;
               nxt_out_col = '0;
            end
            default: begin
               nxt_state   = S_IDLE;
               nxt_kr      = '0;
               nxt_kc      = '0;
               nxt_out_row = '0;
               nxt_out_col = '0;
            end
         endcase
      end
      nxt_busy = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
   end

   // State, outputs and stored config. The config is only writable while
   // not busy, so a load arriving with start still lands but the start check
   // above already used the previous values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cfg_k      <= '0;
         cfg_w      <= '0;
         cfg_h      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cfg_err    <= 1'b0;
         mac_clr    <= 1'b0;
         mac_en     <= 1'b0;
         kr         <= '0;
         kc         <= '0;
         in_row     <= '0;
         in_col     <= '0;
         out_row    <= '0;
         out_col    <= '0;
         psum_valid <= 1'b0;
      end else begin
         if (cfg_load && !busy) begin
            cfg_k <= cfg_kernel;
            cfg_w <= cfg_width;
            cfg_h <= cfg_height;
         end
         state      <= nxt_state;
         busy       <= nxt_busy;
         done       <= nxt_done;
         cfg_err    <= nxt_cfg_err;
         mac_clr    <= nxt_mac_clr;
         mac_en     <= nxt_mac_en;
         kr         <= nxt_kr;
         kc         <= nxt_kc;
         in_row     <= nxt_out_row + DIM_W'(nxt_kr);
         in_col     <= nxt_out_col + DIM_W'(nxt_kc);
         out_row    <= nxt_out_row;
         out_col    <= nxt_out_col;
         psum_valid <= nxt_psum_valid;
      end
   end

endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler
// Directed bench for conv_window_scheduler. Inputs are driven and outputs
// sampled on the falling edge; expected values are hand-computed from the
// layer geometry of each scenario.
module tb_conv_window_scheduler;

   logic       clk;
   logic       rst_n;
   logic       cfg_load;
   logic [2:0] cfg_kernel;
   logic [5:0] cfg_width;
   logic [5:0] cfg_height;
   logic       start;
   logic       abort;
   logic       busy;
   logic       done;
   logic       cfg_err;
   logic       mac_clr;
   logic       mac_en;
   logic [2:0] kr;
   logic [2:0] kc;
   logic [5:0] in_row;
   logic [5:0] in_col;
   logic [5:0] out_row;
   logic [5:0] out_col;
   logic       psum_valid;
   logic       psum_ready;

   int total;
   int bad;

   int hs_row [0:15];
   int hs_col [0:15];
   int hs_cnt;
   int first_valid;
   int done_at;
   int mac_cnt;
   int tap_bad;
   int hold_bad;
   int stall_valid;

   logic [35:0] all_out;
   assign all_out = {busy, done, cfg_err, mac_clr, mac_en, psum_valid,
                     kr, kc, in_row, in_col, out_row, out_col};

   conv_window_scheduler #(.DIM_W(6), .K_W(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_load   (cfg_load),
      .cfg_kernel (cfg_kernel),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err),
      .mac_clr    (mac_clr),
      .mac_en     (mac_en),
      .kr         (kr),
      .kc         (kc),
      .in_row     (in_row),
      .in_col     (in_col),
      .out_row    (out_row),
      .out_col    (out_col),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Loads a new geometry for one cycle.
   task automatic load_cfg(input int k, input int w, input int h);
      @(negedge clk);
      cfg_load   = 1'b1;
      cfg_kernel = 3'(k);
      cfg_width  = 6'(w);
      cfg_height = 6'(h);
      @(negedge clk);
      cfg_load = 1'b0;
   endtask

   // Starts a pass and follows it until done, recording observations.
   // Cycle n=1 is the first cycle after the edge that samples start.
   // The handshake numbered stall_idx is held off for stall_len cycles.
   task automatic run_pass(input int k, input int max_cycles,
                           input int stall_idx, input int stall_len);
      int n, er, ec, stall_rem, vrun;
      logic [5:0] h_row, h_col;
      logic [2:0] h_kr, h_kc;
      hs_cnt = 0; first_valid = -1; done_at = -1; mac_cnt = 0;
      tap_bad = 0; hold_bad = 0; stall_valid = -1;
      er = 0; ec = 0; stall_rem = stall_len; vrun = 0;
      h_row = '0; h_col = '0; h_kr = '0; h_kc = '0;
      psum_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (n <= max_cycles) begin
         if (mac_clr) begin
            er = 0;
            ec = 0;
         end
         if (mac_en) begin
            mac_cnt++;
            if (kr !== 3'(er) || kc !== 3'(ec) ||
                in_row !== out_row + 6'(er) || in_col !== out_col + 6'(ec))
               tap_bad++;
            ec++;
            if (ec == k) begin
               ec = 0;
               er++;
            end
         end
         if (psum_valid) begin
            if (first_valid < 0) first_valid = n;
            if (vrun == 0) begin
               h_row = out_row; h_col = out_col; h_kr = kr; h_kc = kc;
            end else if (out_row !== h_row || out_col !== h_col ||
                         kr !== h_kr || kc !== h_kc || mac_en !== 1'b0) begin
               hold_bad++;
            end
            vrun++;
            if (hs_cnt == stall_idx && stall_rem > 0) begin
               psum_ready = 1'b0;
               stall_rem--;
            end else begin
               psum_ready = 1'b1;
               if (hs_cnt == stall_idx) stall_valid = vrun;
               if (hs_cnt < 16) begin
                  hs_row[hs_cnt] = int'(out_row);
                  hs_col[hs_cnt] = int'(out_col);
               end
               hs_cnt++;
            end
         end else begin
            vrun = 0;
         end
         if (done) begin
            done_at = n;
            break;
         end
         @(negedge clk);
         n++;
      end
      psum_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (all_out !== 36'h0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got %h want 0", all_out);
      end
   endtask

   task automatic test_basic();
      load_cfg(3, 4, 4);
      run_pass(3, 200, -1, 0);
      total++;
      if (first_valid != 12) begin
         bad++;
         $display("[TB] FAIL basic_first_valid: got %0d want 12", first_valid);
      end
      total++;
      if (done_at != 49) begin
         bad++;
         $display("[TB] FAIL basic_done_cycle: got %0d want 49", done_at);
      end
      total++;
      if (mac_cnt != 36) begin
         bad++;
         $display("[TB] FAIL basic_mac_en_count: got %0d want 36", mac_cnt);
      end
      total++;
      if (tap_bad != 0) begin
         bad++;
         $display("[TB] FAIL basic_taps: got %0d bad taps want 0", tap_bad);
      end
      total++;
      if (hs_cnt != 4) begin
         bad++;
         $display("[TB] FAIL basic_hs_count: got %0d want 4", hs_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (hs_row[i] != i / 2 || hs_col[i] != i % 2) begin
            bad++;
            $display("[TB] FAIL basic_hs_order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                     i, hs_row[i], hs_col[i], i / 2, i % 2);
         end
      end
      @(negedge clk);
      total++;
      if ({done, busy} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL basic_after_done: got done,busy=%b want 00", {done, busy});
      end
   endtask

   task automatic test_backpressure();
      run_pass(3, 200, 1, 5);
      total++;
      if (stall_valid != 6) begin
         bad++;
         $display("[TB] FAIL stall_valid_cycles: got %0d want 6", stall_valid);
      end
      total++;
      if (hold_bad != 0) begin
         bad++;
         $display("[TB] FAIL stall_hold_stable: got %0d changes want 0", hold_bad);
      end
      total++;
      if (hs_row[1] != 0 || hs_col[1] != 1) begin
         bad++;
         $display("[TB] FAIL stall_pixel: got (%0d,%0d) want (0,1)", hs_row[1], hs_col[1]);
      end
      total++;
      if (done_at != 54) begin
         bad++;
         $display("[TB] FAIL stall_done_cycle: got %0d want 54", done_at);
      end
   endtask

   task automatic test_bad_cfg();
      int seen;
      load_cfg(5, 4, 6);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({cfg_err, busy, mac_clr} !== 3'b100) begin
         bad++;
         $display("[TB] FAIL badcfg_err_pulse: got err,busy,clr=%b want 100",
                  {cfg_err, busy, mac_clr});
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (cfg_err || busy || mac_en || psum_valid) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("[TB] FAIL badcfg_quiet: got %0d active cycles want 0", seen);
      end
      load_cfg(3, 4, 4);
      run_pass(3, 200, -1, 0);
      total++;
      if (done_at != 49 || hs_cnt != 4) begin
         bad++;
         $display("[TB] FAIL badcfg_reload_pass: got done=%0d hs=%0d want 49 4",
                  done_at, hs_cnt);
      end
   endtask

   task automatic test_k1();
      load_cfg(1, 2, 2);
      run_pass(1, 100, -1, 0);
      total++;
      if (first_valid != 4) begin
         bad++;
         $display("[TB] FAIL k1_first_valid: got %0d want 4", first_valid);
      end
      total++;
      if (done_at != 17) begin
         bad++;
         $display("[TB] FAIL k1_done_cycle: got %0d want 17", done_at);
      end
      total++;
      if (mac_cnt != 4 || tap_bad != 0) begin
         bad++;
         $display("[TB] FAIL k1_taps: got mac=%0d badtaps=%0d want 4 0", mac_cnt, tap_bad);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (hs_row[i] != i / 2 || hs_col[i] != i % 2) begin
            bad++;
            $display("[TB] FAIL k1_hs_order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                     i, hs_row[i], hs_col[i], i / 2, i % 2);
         end
      end
   endtask

   task automatic test_abort();
      int guard, seen;
      load_cfg(3, 5, 5);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!(mac_en && kr == 3'd1 && kc == 3'd2) && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 50) begin
         bad++;
         $display("[TB] FAIL abort_reach_tap: got timeout want tap (1,2)");
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      total++;
      if (all_out !== 36'h0) begin
         bad++;
         $display("[TB] FAIL abort_outputs: got %h want 0", all_out);
      end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles want 0", seen);
      end
      run_pass(3, 300, -1, 0);
      total++;
      if (done_at != 109 || hs_cnt != 9) begin
         bad++;
         $display("[TB] FAIL abort_rerun: got done=%0d hs=%0d want 109 9", done_at, hs_cnt);
      end
      total++;
      if (hs_row[0] != 0 || hs_col[0] != 0 || hs_row[8] != 2 || hs_col[8] != 2) begin
         bad++;
         $display("[TB] FAIL abort_rerun_order: got first (%0d,%0d) last (%0d,%0d) want (0,0) (2,2)",
                  hs_row[0], hs_col[0], hs_row[8], hs_col[8]);
      end
   endtask

   task automatic test_reset_midpass();
      int guard;
      load_cfg(3, 4, 4);
      psum_ready = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (!psum_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 50) begin
         bad++;
         $display("[TB] FAIL midreset_reach_wait: got timeout want psum_valid");
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      psum_ready = 1'b1;
      total++;
      if (all_out !== 36'h0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs: got %h want 0", all_out);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if ({cfg_err, busy} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL midreset_cfg_cleared: got err,busy=%b want 10", {cfg_err, busy});
      end
   endtask

   // Scenarios run in order; each leaves the scheduler idle for the next.
   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      cfg_load = 1'b0;
      cfg_kernel = '0;
      cfg_width = '0;
      cfg_height = '0;
      start = 1'b0;
      abort = 1'b0;
      psum_ready = 1'b1;
      test_reset();
      test_basic();
      test_backpressure();
      test_bad_cfg();
      test_k1();
      test_abort();
      test_reset_midpass();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
